// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: defaults, FSM encoding, lane helpers.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int LANES_DEF = 4;
    localparam int MAX_LANES = 32;

    typedef enum logic {
        ACC   = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    // acc_cnt must hold 0..LANES inclusive
    function automatic int cnt_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic logic [MAX_LANES-1:0] keep_mask(input int cnt);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < cnt) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pack_out_slot.sv
// Valid/ready holding register for packed output words: load, hold under backpressure, clear on handshake.
module pack_out_slot
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DSIZE*LANES-1:0] load_data,
    input  logic [LANES-1:0]       load_keep,
    input  logic                   load_last,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DSIZE*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_last
);

    // The parent only asserts load when the slot is empty or being accepted this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read port and packs LANES entries little-endian into one wide valid/ready word.
// Optional idle auto-flush is built only when PACK_TIMEOUT_EN is defined.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE   = DSIZE_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CNT_W = cnt_width(LANES);

    logic [LANES-1:0][DSIZE-1:0] acc;
    logic [LANES-1:0][DSIZE-1:0] word;
    logic [DSIZE*LANES-1:0]      word_flat;
    logic [CNT_W-1:0]            acc_cnt;
    logic [CNT_W-1:0]            acc_cnt_next;
    logic [CNT_W-1:0]            lane;
    logic [LANES-1:0]            keep;
    pack_state_t                 state;
    pack_state_t                 state_next;
    logic                        to_close;
    logic                        to_close_next;
    logic                        full;
    logic                        slot_free;
    logic                        xfer;
    logic                        pop;
    logic                        word_last;
    logic                        to_fire;

    assign full      = (acc_cnt == CNT_W'(LANES));
    assign slot_free = ~out_valid | out_ready;

    // A full accumulator may still pop when it empties into the slot the same edge;
    // a flush on that edge closes the full word instead, so the pop is held back.
    always_comb begin
        xfer = slot_free & (full | ((state == FLUSH) & (acc_cnt != '0)));
        pop  = rrst_n & ~rempty & (state == ACC) & (~full | (slot_free & ~flush));
    end

    assign rinc = pop;

    always_comb begin
        lane         = xfer ? '0 : acc_cnt;
        acc_cnt_next = xfer ? CNT_W'(pop) : acc_cnt + CNT_W'(pop);
        keep         = LANES'(keep_mask(int'(acc_cnt)));
        word_last    = (state == FLUSH) ? ~to_close : flush;
        word         = '0;
        for (int i = 0; i < LANES; i++) begin
            if (keep[i]) word[i] = acc[i];
        end
    end

    assign word_flat = word;

    always_comb begin
        state_next    = state;
        to_close_next = to_close;
        case (state)
            ACC: begin
                if (flush && !xfer) begin
                    state_next    = FLUSH;
                    to_close_next = 1'b0;
                end else if (to_fire) begin
                    state_next    = FLUSH;
                    to_close_next = 1'b1;
                end
            end
            FLUSH: begin
                if (xfer || acc_cnt == '0) begin
                    state_next    = ACC;
                    to_close_next = 1'b0;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state    <= ACC;
            acc_cnt  <= '0;
            to_close <= 1'b0;
        end else begin
            state    <= state_next;
            acc_cnt  <= acc_cnt_next;
            to_close <= to_close_next;
        end
    end

    always_ff @(posedge rclk) begin
        for (int i = 0; i < LANES; i++) begin
            if (pop && lane == CNT_W'(i)) acc[i] <= rdata;
        end
    end

`ifdef PACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_cond;

    assign to_cond = (state == ACC) & rempty & (acc_cnt != '0) & ~full;
    assign to_fire = to_cond & (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge rclk) begin
        if (!rrst_n || state != ACC || pop || xfer || to_fire) begin
            to_cnt <= '0;
        end else if (to_cond) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // No idle auto-flush in this build; partial words wait for data or flush.
    assign to_fire = (TIMEOUT < 0);
`endif

    pack_out_slot #(
        .DSIZE(DSIZE),
        .LANES(LANES)
    ) u_slot (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .load     (xfer),
        .load_data(word_flat),
        .load_keep(keep),
        .load_last(word_last),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed scenarios plus random traffic against a queue-based reference model.
module tb_fifo_rd_packer;

    localparam int DSIZE   = 8;
    localparam int LANES   = 4;
    localparam int TIMEOUT = 16;

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        rempty = 1'b1;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        rinc;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DSIZE(DSIZE),
        .LANES(LANES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rdata    (rdata),
        .rempty   (rempty),
        .rinc     (rinc),
        .flush    (flush),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: FIFO contents, accumulated entries, flush mode, output slot
    logic [7:0]  fifo_q[$];
    logic [7:0]  acc_q[$];
    bit          m_flush;
    bit          m_to;
    int          m_tcnt;
    bit          s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    bit          s_last;

    int          rinc_hits;
    int          rinc_run;
    int          rinc_max;
    int          words_seen;
    logic [31:0] last_word;
    logic [3:0]  last_keep;
    logic        last_last;

    task automatic sync_fifo();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        sync_fifo();
    endtask

    task automatic step();
        int cnt0;
        bit full;
        bit free;
        bit e_xfer;
        bit e_pop;
        bit fire;
        @(negedge rclk);
        cnt0   = acc_q.size();
        full   = (cnt0 == LANES);
        free   = !s_valid || out_ready;
        e_xfer = free && (full || (m_flush && cnt0 > 0));
        e_pop  = rrst_n && fifo_q.size() > 0 && !m_flush && (!full || (free && !flush));
        chk("rinc", rinc, e_pop);
        chk("out_valid", out_valid, s_valid);
        if (s_valid) begin
            chk("out_data", out_data, s_data);
            chk("out_keep", out_keep, s_keep);
            chk("out_last", out_last, s_last);
        end
        if (out_valid && out_ready) begin
            last_word = out_data;
            last_keep = out_keep;
            last_last = out_last;
            words_seen++;
        end
        if (rinc) begin
            rinc_hits++;
            rinc_run++;
            if (rinc_run > rinc_max) rinc_max = rinc_run;
        end else begin
            rinc_run = 0;
        end
        @(posedge rclk);
        #1;
        fire = 1'b0;
        if (!rrst_n) begin
            acc_q.delete();
            m_flush = 0;
            m_to    = 0;
            m_tcnt  = 0;
            s_valid = 0;
            s_data  = '0;
            s_keep  = '0;
            s_last  = 0;
        end else begin
`ifdef PACK_TIMEOUT_EN
            begin
                bit cond;
                cond = !m_flush && fifo_q.size() == 0 && cnt0 > 0 && cnt0 < LANES;
                fire = cond && (m_tcnt == TIMEOUT - 1);
                if (m_flush || e_pop || e_xfer || fire) m_tcnt = 0;
                else if (cond) m_tcnt++;
            end
`endif
            if (e_xfer) begin
                s_valid = 1;
                s_data  = '0;
                for (int i = 0; i < cnt0; i++) s_data[8*i +: 8] = acc_q[i];
                s_keep  = 4'((1 << cnt0) - 1);
                s_last  = m_flush ? !m_to : flush;
                acc_q.delete();
            end else if (out_ready) begin
                s_valid = 0;
            end
            if (e_pop) acc_q.push_back(fifo_q.pop_front());
            if (!m_flush) begin
                if (flush && !e_xfer) begin
                    m_flush = 1;
                    m_to    = 0;
                end else if (fire) begin
                    m_flush = 1;
                    m_to    = 1;
                end
            end else if (e_xfer || cnt0 == 0) begin
                m_flush = 0;
                m_to    = 0;
            end
        end
        sync_fifo();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int k;
        sync_fifo();
        rinc_hits = 0;
        rinc_run = 0;
        rinc_max = 0;
        words_seen = 0;

        // reset state
        rrst_n = 1'b0;
        step();
        step();
        chk("rst_data", out_data, 32'h0);
        chk("rst_keep", out_keep, 4'h0);
        chk("rst_last", out_last, 1'b0);
        rrst_n = 1'b1;

        // single full word
        out_ready = 1'b1;
        rinc_hits = 0;
        words_seen = 0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (8) step();
        chk("t1_rinc_cnt", rinc_hits, 4);
        chk("t1_words", words_seen, 1);
        chk("t1_word", last_word, 32'h44332211);
        chk("t1_keep", last_keep, 4'hF);
        chk("t1_last", last_last, 1'b0);

        // backpressure then release
        out_ready = 1'b0;
        for (int v = 1; v <= 12; v++) push(8'(v));
        repeat (12) step();
        chk("t2_held_data", out_data, 32'h04030201);
        chk("t2_stall_rinc", rinc, 1'b0);
        out_ready = 1'b1;
        words_seen = 0;
        repeat (20) step();
        chk("t2_words", words_seen, 3);
        chk("t2_last_word", last_word, 32'h0C0B0A09);

        // partial flush
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        chk("t3_word", last_word, 32'h00A3A2A1);
        chk("t3_keep", last_keep, 4'h7);
        chk("t3_last", last_last, 1'b1);
        words_seen = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        chk("t3_empty_flush", words_seen, 0);

        // reset mid-word
        push(8'hE1); push(8'hE2);
        repeat (3) step();
        rrst_n = 1'b0;
        step();
        chk("t4_rst_valid", out_valid, 1'b0);
        chk("t4_rst_data", out_data, 32'h0);
        rrst_n = 1'b1;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        words_seen = 0;
        repeat (8) step();
        chk("t4_words", words_seen, 1);
        chk("t4_word", last_word, 32'h88776655);
        chk("t4_keep", last_keep, 4'hF);

        // sustained throughput from a preloaded FIFO
        for (int v = 0; v < 8; v++) push(8'(8'hC0 + v));
        rinc_hits = 0;
        rinc_run = 0;
        rinc_max = 0;
        words_seen = 0;
        repeat (12) step();
        chk("t5_rinc_cnt", rinc_hits, 8);
        chk("t5_rinc_run", rinc_max, 8);
        chk("t5_words", words_seen, 2);
        chk("t5_last_word", last_word, 32'hC7C6C5C4);

        // idle partial word
        words_seen = 0;
        push(8'hB1); push(8'hB2);
        repeat (2) step();
`ifdef PACK_TIMEOUT_EN
        k = 0;
        while (k < 40 && !out_valid) begin
            step();
            k++;
        end
        chk("t6_latency", k, 17);
        step();
        chk("t6_word", last_word, 32'h0000B2B1);
        chk("t6_keep", last_keep, 4'h3);
        chk("t6_last", last_last, 1'b0);
`else
        k = 0;
        repeat (100) step();
        chk("t6_no_word", words_seen, k);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        chk("t6_flushed", last_word, 32'h0000B2B1);
`endif

        // random traffic
        repeat (3000) begin
            if ($urandom_range(0, 99) < 45 && fifo_q.size() < 16) push(8'($urandom));
            if ($urandom_range(0, 99) < 10 && fifo_q.size() < 16) push(8'($urandom));
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 4);
            rrst_n    = ($urandom_range(0, 999) != 0);
            step();
        end
        flush = 1'b0;
        rrst_n = 1'b1;
        out_ready = 1'b1;
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
